mesh_term_rx: RTL
=================

// Module: mesh_term_rx
// PURPOSE
//  Synthesizable terminal-side receiver for one mesh_gnrtr output port; the sink end of the pndng/data_out/pop protocol.
//  Pops packets the router presents on pndng/data_out and checks the destination field against this terminal's ID or bdcst.
//  Buffers accepted packets in a local FIFO, drained by a valid/ready consumer. Misrouted packets are dropped and counted.
// PARAMETERS
//  ROWS        4       mesh rows (informational; used for MY_ROW range assertion)
//  COLUMS      4       mesh columns (informational; used for MY_COL range assertion)
//  pckg_sz     40      packet width, bits
//  fifo_depth  4       local packet FIFO depth, entries; >=2
//  bdcst       8'hFF   broadcast destination value for {row,colum}
//  MY_ROW      2       row ID of this terminal, 4 bits
//  MY_COL      0       column ID of this terminal, 4 bits
//  CNT_W       16      width of the statistics counters
// PORTS
//  clk        in   1        clock; everything on rising edge
//  reset      in   1        asynchronous, active-low reset
//  pndng      in   1        router has a packet pending on data_out
//  data_out   in   pckg_sz  router packet (show-ahead; valid while pndng=1)
//  pop        out  1        one-cycle pulse; consumes the packet on data_out
//  out_valid  out  1        local FIFO not empty
//  out_data   out  pckg_sz  head packet of the local FIFO (full packet, header intact)
//  out_ready  in   1        consumer accepts out_data when out_valid & out_ready
//  rx_count   out  CNT_W    packets accepted, saturating
//  err_count  out  CNT_W    packets dropped as misrouted, saturating
//  busy       out  1        FSM not in IDLE
// BEHAVIOUR
//  Packet fields:
//   - Nxtjp  = [pckg_sz-1:pckg_sz-8]
//   - row    = [pckg_sz-9:pckg_sz-12]
//   - colum  = [pckg_sz-13:pckg_sz-16]
//   - mode   = [pckg_sz-17]
//   - payload = [pckg_sz-18:0]
//  Reset (reset=0, async): all outputs 0, state=IDLE, FIFO emptied, counters 0. Reset mid-transfer drops any latched packet.
//  FSM, one packet per 3 cycles max:
//   - IDLE: if pndng & !fifo_full -> POP; else stay.
//   - POP: pop=1 for exactly this cycle; data_out registered into hold_q in the same edge -> CHECK.
//   - CHECK: dest={hold_q.row,hold_q.colum}.
//     - dest=={MY_ROW,MY_COL} or dest==bdcst: push hold_q to the FIFO; rx_count++.
//     - otherwise: discard; err_count++.
//     - -> IDLE. pndng is ignored in CHECK because the router updates it one cycle after pop.
//  pop is never asserted when pndng=0 and never on two consecutive cycles.
//  Full FIFO: IDLE does not issue pop; the router keeps pndng high (backpressure). Overflow is impossible because the FIFO has a single writer.
//  FIFO read:
//   - out_valid = !empty. Pop the head on out_valid & out_ready.
//   - Simultaneous push (CHECK) and read on a full FIFO is legal; occupancy stays the same.
//   - Wrap-around: pointers modulo fifo_depth, with an extra occupancy counter, width $clog2(fifo_depth+1).
//  Counters: increment by 1, hold at {CNT_W{1'b1}}, no wrap.
//  mode and Nxtjp are not checked; they pass through in out_data unchanged.
//  Latency: pndng rise -> pop = 1 cycle; pop -> out_valid = 2 cycles when the FIFO is empty.
//  Assertions:
//   - pop -> pndng
//   - !(pop && $past(pop))
//   - MY_ROW<ROWS+2, MY_COL<COLUMS+2
// STRUCTURE
//  mesh_pkg:
//   - field-offset localparams / functions get_row(), get_col(), get_mode(), get_payload()
//   - rx_state_e {IDLE,POP,CHECK}
//   - bdcst default
//  Sub-module mesh_term_fifo: sync FIFO with push/pop/full/empty/count.
//  Top level: FSM, hold_q, destination compare, counters.
// TESTING (pckg_sz=40, MY_ROW=2, MY_COL=0, fifo_depth=4)
//  1 Reset: hold reset=0 for 5 cycles with pndng=1 -> pop=0, out_valid=0, counters=0 throughout.
//  2 Match: data_out=40'h00_20_00_00_01, pndng=1 for 1 packet -> one pop pulse; 2 cycles later out_valid=1, out_data=40'h0020000001, rx_count=1.
//  3 Misroute: packet with row=1, col=3 (40'h00_13_00_00_07) -> popped once; out_valid stays 0; err_count=1.
//  4 Broadcast: row/col=8'hFF -> accepted, rx_count increments.
//  5 Backpressure: out_ready=0, 6 matching packets offered -> exactly 4 pops; pndng held; no pop while full. Then out_ready=1 -> remaining 2 popped; 6 delivered in order.
//  6 Async reset asserted in the POP cycle -> pop drops immediately; FIFO empty; counters 0; no packet delivered.

Source files
------------

// File: rtl/mesh_pkg.sv
// Shared definitions for the mesh terminal receiver: header field
// extraction, receive FSM states and the default broadcast destination.
// Header layout, MSB first: Nxtjp[7:0], row[3:0], colum[3:0], mode.
package mesh_pkg;

  localparam int unsigned NXTJP_W = 8;
  localparam int unsigned ROW_W   = 4;
  localparam int unsigned COL_W   = 4;
  localparam int unsigned HDR_W   = NXTJP_W + ROW_W + COL_W + 1;
  localparam int unsigned PKT_MAX = 128;

  localparam logic [7:0] BDCST_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    CHECK = 2'd2
  } rx_state_e;

  // Field helpers take the top HDR_W bits of a packet.
  function automatic logic [ROW_W-1:0] get_row(input logic [HDR_W-1:0] hdr);
    return hdr[HDR_W-NXTJP_W-1 -: ROW_W];
  endfunction

  function automatic logic [COL_W-1:0] get_col(input logic [HDR_W-1:0] hdr);
    return hdr[HDR_W-NXTJP_W-ROW_W-1 -: COL_W];
  endfunction

  function automatic logic get_mode(input logic [HDR_W-1:0] hdr);
    return hdr[0];
  endfunction

  // Payload is everything below the header; sz is the packet width.
  function automatic logic [PKT_MAX-1:0] get_payload(input logic [PKT_MAX-1:0] pkt,
                                                     input int unsigned sz);
    logic [PKT_MAX-1:0] mask;
    mask = (PKT_MAX'(1) << (sz - HDR_W)) - PKT_MAX'(1);
    return pkt & mask;
  endfunction

endpackage

// File: rtl/mesh_term_fifo.sv
// Synchronous packet FIFO with a show-ahead head.
// Ports: clk, reset (async active-low), push/push_data (write),
//        pop (read head), pop_data (head entry), full, empty, count.
module mesh_term_fifo #(
  parameter int unsigned W     = 40,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [W-1:0]                 pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // A push on a full FIFO is only taken when the head leaves the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage and pointers; pointers wrap at DEPTH so any depth works.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mesh_term_rx.sv
// Terminal-side receiver for one mesh router output port.
// Pops packets on pndng/data_out, keeps those addressed to {MY_ROW,MY_COL}
// or broadcast, drops and counts the rest, and queues kept packets for a
// valid/ready consumer.
// Ports: clk, reset (async active-low), pndng, data_out, pop,
//        out_valid, out_data, out_ready, rx_count, err_count, busy.
module mesh_term_rx
  import mesh_pkg::*;
#(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLUMS     = 4,
  parameter int unsigned pckg_sz    = 40,
  parameter int unsigned fifo_depth = 4,
  parameter logic [7:0]  bdcst      = BDCST_DEFAULT,
  parameter int unsigned MY_ROW     = 2,
  parameter int unsigned MY_COL     = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pndng,
  input  logic [pckg_sz-1:0] data_out,
  output logic               pop,
  output logic               out_valid,
  output logic [pckg_sz-1:0] out_data,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   rx_count,
  output logic [CNT_W-1:0]   err_count,
  output logic               busy
);

  localparam int unsigned CW = $clog2(fifo_depth+1);
  localparam logic [7:0]  MY_ID = {4'(MY_ROW), 4'(MY_COL)};

  rx_state_e          state_q;
  rx_state_e          state_d;
  logic [pckg_sz-1:0] hold_q;
  logic [HDR_W-1:0]   hdr;
  logic [7:0]         dest;
  logic               dest_ok;
  logic               accept;
  logic               reject;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;

  assign hdr     = hold_q[pckg_sz-1 -: HDR_W];
  assign dest    = {get_row(hdr), get_col(hdr)};
  assign dest_ok = (dest == MY_ID) || (dest == bdcst);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state. pndng is stale in CHECK, so only IDLE looks at it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pndng && !fifo_full) state_d = POP;
      POP:     state_d = CHECK;
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the state register.
  always_comb begin
    pop    = 1'b0;
    busy   = 1'b0;
    accept = 1'b0;
    reject = 1'b0;
    pop    = (state_q == POP);
    busy   = (state_q != IDLE);
    accept = (state_q == CHECK) && dest_ok;
    reject = (state_q == CHECK) && !dest_ok;
  end

  // Packet latch and saturating statistics.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q    <= '0;
      rx_count  <= '0;
      err_count <= '0;
    end else begin
      if (state_q == POP) hold_q <= data_out;
      if (accept && (rx_count != '1))  rx_count  <= rx_count + CNT_W'(1);
      if (reject && (err_count != '1)) err_count <= err_count + CNT_W'(1);
    end
  end

  mesh_term_fifo #(
    .W     (pckg_sz),
    .DEPTH (fifo_depth)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (hold_q),
    .pop       (out_ready),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;

`ifndef SYNTHESIS
  a_pop_pndng: assert property (@(posedge clk) disable iff (!reset) pop |-> pndng);
  a_pop_gap:   assert property (@(posedge clk) disable iff (!reset) pop |=> !pop);
  a_count:     assert property (@(posedge clk) disable iff (!reset)
                                fifo_count <= CW'(fifo_depth));
  a_params:    assert property (@(posedge clk)
                                (MY_ROW < ROWS + 2) && (MY_COL < COLUMS + 2) && (fifo_depth >= 2));
`endif

endmodule
